// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic-light controller timing blocks.
package traffic_pkg;

    typedef enum logic [0:0] {IDLE, RUN} cd_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Saturate an arbitrary nibble into the legal BCD range.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_countdown_if.sv
// Control/status bundle between the phase controller and the BCD countdown timer.
interface bcd_countdown_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   preset;
    logic                  tick;
    logic                  hold;
    logic [4*DIGITS-1:0]   q;
    logic                  running;
    logic                  done;
    logic                  bo;

    modport master (
        output load, preset, tick, hold,
        input  q, running, done, bo
    );

    modport slave (
        input  load, preset, tick, hold,
        output q, running, done, bo
    );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: synchronous load, decrement with wrap 0 -> 9.
module bcd_down_digit
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       dec,
    input  logic       ld,
    input  logic [3:0] d,
    output logic [3:0] Q,
    output logic       BO
);

    // Digit register: load wins over decrement.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            Q <= 4'd0;
        end else if (ld) begin
            Q <= d;
        end else if (dec) begin
            Q <= (Q == 4'd0) ? BCD_MAX : Q - 4'd1;
        end
    end

    // Borrow into the next more-significant digit.
    assign BO = dec & (Q == 4'd0);

endmodule

// File: rtl/bcd_countdown.sv
// Multi-digit BCD phase timer: load, pause, count down on tick, pulse done at 00.
module bcd_countdown
    import traffic_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic           clk,
    input  logic           rstn,
    bcd_countdown_if.slave bus
);

    localparam int unsigned W = 4 * DIGITS;

    cd_state_t         state_q, state_d;
    logic              done_q, done_d;
    logic [W-1:0]      preset_clamped;
    logic [DIGITS:0]   borrow;
    logic              qual_tick;
    logic              preset_nz;
    logic              at_one;

    assign qual_tick = (state_q == RUN) & bus.tick & ~bus.hold & ~bus.load;
    assign borrow[0] = qual_tick;
    assign preset_nz = (preset_clamped != '0);
    assign at_one    = (bus.q == W'(1));

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign preset_clamped[4*i +: 4] = bcd_clamp(bus.preset[4*i +: 4]);

        bcd_down_digit u_digit (
            .clk  (clk),
            .rstn (rstn),
            .dec  (borrow[i]),
            .ld   (bus.load),
            .d    (preset_clamped[4*i +: 4]),
            .Q    (bus.q[4*i +: 4]),
            .BO   (borrow[i+1])
        );
    end

    // State and expiry-pulse registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next state: a load always (re)starts; the last decrement from 01 expires the phase.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (bus.load) begin
            state_d = preset_nz ? RUN : IDLE;
        end else if (qual_tick && at_one) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    assign bus.running = (state_q == RUN);
    assign bus.done    = done_q;
    // Borrow out of the top digit; only reachable if RUN were ever entered at zero.
    assign bus.bo      = borrow[DIGITS];

endmodule
